// File: rtl/dpcm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dpcm_pkg
// Description : Shared types and constants for the DPCM encoder/decoder pair.
// Revision    : 1.0 - initial release
// ============================================================================
package dpcm_pkg;

    typedef logic [7:0]        sample_t;
    typedef logic signed [7:0] diff_t;

    typedef enum logic [0:0] {
        ABS   = 1'b0,
        DELTA = 1'b1
    } dpcm_state_t;

    localparam sample_t SAMPLE_MIN     = 8'd0;
    localparam sample_t SAMPLE_MAX     = 8'd255;
    localparam int      DEFAULT_RESYNC = 16;

endpackage
`default_nettype wire

// File: rtl/dpcm_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : dpcm_decoder_if
// Description : Code-in / sample-out handshake bundle plus status for the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface dpcm_decoder_if #(
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          sync;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          sat_err;
    logic          sat_clr;
    logic [7:0]    sample_cnt;

    modport master (
        output in_valid, in_data, sync, out_ready, sat_clr,
        input  in_ready, out_valid, out_data, sat_err, sample_cnt
    );

    modport slave (
        input  in_valid, in_data, sync, out_ready, sat_clr,
        output in_ready, out_valid, out_data, sat_err, sample_cnt
    );
endinterface
`default_nettype wire

// File: rtl/dpcm_sat_add.sv
`default_nettype none
// ============================================================================
// Module      : dpcm_sat_add
// Description : Predictor plus signed difference, clamped to the sample range.
// Revision    : 1.0 - initial release
// ============================================================================
module dpcm_sat_add
    import dpcm_pkg::*;
(
    input  sample_t i_pred,
    input  diff_t   i_diff,
    output sample_t o_sum,
    output logic    o_clamp
);

    // Ten bits hold every possible 0..255 + -128..127 result without wrap.
    logic signed [9:0] w_sum;

    assign w_sum = $signed({2'b00, i_pred}) + $signed({{2{i_diff[7]}}, i_diff});

    always_comb begin
        o_sum   = w_sum[7:0];
        o_clamp = 1'b0;
        if (w_sum < $signed({2'b00, SAMPLE_MIN})) begin
            o_sum   = SAMPLE_MIN;
            o_clamp = 1'b1;
        end else if (w_sum > $signed({2'b00, SAMPLE_MAX})) begin
            o_sum   = SAMPLE_MAX;
            o_clamp = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dpcm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : dpcm_decoder
// Description : Keyframe + delta DPCM reconstruction with saturation and resync.
// Revision    : 1.0 - initial release
// ============================================================================
module dpcm_decoder
    import dpcm_pkg::*;
#(
    parameter int RESYNC_PERIOD = DEFAULT_RESYNC,
    parameter int DW            = 8
) (
    input  logic          clk,
    input  logic          rst,
    dpcm_decoder_if.slave bus
);

    localparam logic [7:0] c_period = 8'(RESYNC_PERIOD);

    dpcm_state_t   r_state, w_state_nx;
    // The predictor is also the output register: both only change on accept.
    sample_t       r_pred, w_pred_nx;
    logic [7:0]    r_cnt, w_cnt_nx, w_cnt_inc;
    logic          r_out_valid, w_out_valid_nx;
    logic          r_sat_err, w_sat_err_nx;
    logic          r_sync_pend, w_sync_pend_nx;

    logic [DW-1:0] w_code;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_abs;
    sample_t       w_sum;
    logic          w_clamp;

    assign w_code     = bus.in_data;
    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_abs      = (r_state == ABS) || bus.sync || r_sync_pend;
    assign w_cnt_inc  = r_cnt + 8'd1;

    dpcm_sat_add u_sat_add (
        .i_pred  (r_pred),
        .i_diff  (diff_t'(w_code)),
        .o_sum   (w_sum),
        .o_clamp (w_clamp)
    );

    always_comb begin
        w_state_nx     = r_state;
        w_pred_nx      = r_pred;
        w_cnt_nx       = r_cnt;
        w_out_valid_nx = r_out_valid;
        w_sync_pend_nx = r_sync_pend;
        w_sat_err_nx   = r_sat_err && !bus.sat_clr;

        if (w_accept) begin
            w_out_valid_nx = 1'b1;
            w_sync_pend_nx = 1'b0;
            if (w_abs) begin
                w_pred_nx = sample_t'(w_code);
                if (RESYNC_PERIOD == 1) begin
                    w_state_nx = ABS;
                    w_cnt_nx   = 8'd0;
                end else begin
                    w_state_nx = DELTA;
                    w_cnt_nx   = 8'd1;
                end
            end else begin
                w_pred_nx  = w_sum;
                w_state_nx = DELTA;
                if (w_clamp) begin
                    w_sat_err_nx = 1'b1;
                end
                if (RESYNC_PERIOD != 0 && w_cnt_inc == c_period) begin
                    w_cnt_nx   = 8'd0;
                    w_state_nx = ABS;
                end else if (RESYNC_PERIOD == 0 && w_cnt_inc == 8'd0) begin
                    // Free-running mode: slot 0 stays reserved for the keyframe.
                    w_cnt_nx = 8'd1;
                end else begin
                    w_cnt_nx = w_cnt_inc;
                end
            end
        end else begin
            if (bus.sync) begin
                w_sync_pend_nx = 1'b1;
            end
            if (bus.out_ready) begin
                w_out_valid_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ABS;
            r_pred      <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_sat_err   <= 1'b0;
            r_sync_pend <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_pred      <= w_pred_nx;
            r_cnt       <= w_cnt_nx;
            r_out_valid <= w_out_valid_nx;
            r_sat_err   <= w_sat_err_nx;
            r_sync_pend <= w_sync_pend_nx;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_pred;
    assign bus.sat_err    = r_sat_err;
    assign bus.sample_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dpcm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dpcm_decoder
// Description : Scenario and randomized checks of dpcm_decoder against a sample model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dpcm_decoder;

    localparam int RESYNC = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dpcm_decoder_if #(.DW(8)) bus ();

    dpcm_decoder #(
        .RESYNC_PERIOD (RESYNC),
        .DW            (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: last emitted sample, its valid flag, group position, flags.
    bit m_ov;
    int m_out;
    bit m_sat;
    int m_pos;
    bit m_pend;

    task automatic drive(input bit v, input int code, input bit s, input bit ordy,
                         input bit clr, input bit r);
        bit acc;
        bit clamp;
        int d;
        int t;
        rst           = r;
        bus.in_valid  = v;
        bus.in_data   = code[7:0];
        bus.sync      = s;
        bus.out_ready = ordy;
        bus.sat_clr   = clr;
        acc   = v && (!m_ov || ordy);
        clamp = 0;
        if (r) begin
            m_ov = 0; m_out = 0; m_sat = 0; m_pos = 0; m_pend = 0;
        end else begin
            if (acc) begin
                if (m_pos == 0 || s || m_pend) begin
                    m_out = code & 255;
                    m_pos = (RESYNC == 1) ? 0 : 1;
                end else begin
                    d = code & 255;
                    if (d >= 128) d = d - 256;
                    t = m_out + d;
                    if (t < 0) begin m_out = 0; clamp = 1; end
                    else if (t > 255) begin m_out = 255; clamp = 1; end
                    else m_out = t;
                    m_pos++;
                    if (RESYNC != 0 && m_pos == RESYNC) m_pos = 0;
                    else if (RESYNC == 0 && m_pos == 256) m_pos = 1;
                end
                m_ov   = 1;
                m_pend = 0;
            end else begin
                if (s) m_pend = 1;
                if (ordy) m_ov = 0;
            end
            m_sat = (m_sat && !clr) || clamp;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 1);
        checks += 5;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
        if (bus.out_data !== 8'd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", bus.out_data); end
        if (bus.sat_err !== 1'b0) begin errors++; $display("FAIL reset_sat_err: got %0b want 0", bus.sat_err); end
        if (bus.sample_cnt !== 8'd0) begin errors++; $display("FAIL reset_sample_cnt: got %0d want 0", bus.sample_cnt); end
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
        drive(0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_basic();
        int codes [4] = '{100, 5, -10, 0};
        int exp_d [4] = '{100, 105, 95, 95};
        int exp_c [4] = '{1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            drive(1, codes[i], 0, 1, 0, 0);
            checks += 3;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d]: got %0b want 1", i, bus.out_valid); end
            if (bus.out_data !== 8'(exp_d[i])) begin errors++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, bus.out_data, exp_d[i]); end
            if (bus.sample_cnt !== 8'(exp_c[i])) begin errors++; $display("FAIL basic_cnt[%0d]: got %0d want %0d", i, bus.sample_cnt, exp_c[i]); end
        end
        checks++;
        if (bus.sat_err !== 1'b0) begin errors++; $display("FAIL basic_sat: got %0b want 0", bus.sat_err); end
    endtask

    task automatic test_saturation();
        int codes [4] = '{250, 20, 5, -128};
        bit syncs [4] = '{1, 0, 1, 0};
        bit clrs  [4] = '{0, 0, 0, 1};
        int exp_d [4] = '{250, 255, 5, 0};
        bit exp_s [4] = '{0, 1, 1, 1};
        for (int i = 0; i < 4; i++) begin
            drive(1, codes[i], syncs[i], 1, clrs[i], 0);
            checks += 2;
            if (bus.out_data !== 8'(exp_d[i])) begin errors++; $display("FAIL sat_data[%0d]: got %0d want %0d", i, bus.out_data, exp_d[i]); end
            if (bus.sat_err !== exp_s[i]) begin errors++; $display("FAIL sat_flag[%0d]: got %0b want %0b", i, bus.sat_err, exp_s[i]); end
        end
        drive(0, 0, 0, 1, 1, 0);
        checks++;
        if (bus.sat_err !== 1'b0) begin errors++; $display("FAIL sat_clear: got %0b want 0", bus.sat_err); end
    endtask

    task automatic test_resync();
        int codes [6] = '{10, 1, 1, 1, 200, 1};
        int exp_d [6] = '{10, 11, 12, 13, 200, 201};
        int exp_c [6] = '{1, 2, 3, 0, 1, 2};
        for (int i = 0; i < 6; i++) begin
            drive(1, codes[i], (i == 0), 1, 0, 0);
            checks += 2;
            if (bus.out_data !== 8'(exp_d[i])) begin errors++; $display("FAIL resync_data[%0d]: got %0d want %0d", i, bus.out_data, exp_d[i]); end
            if (bus.sample_cnt !== 8'(exp_c[i])) begin errors++; $display("FAIL resync_cnt[%0d]: got %0d want %0d", i, bus.sample_cnt, exp_c[i]); end
        end
    endtask

    task automatic test_backpressure();
        drive(1, 7, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 0, 0, 0, 0);
            checks += 3;
            if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, bus.in_ready); end
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %0b want 1", i, bus.out_valid); end
            if (bus.out_data !== 8'd208) begin errors++; $display("FAIL bp_hold[%0d]: got %0d want 208", i, bus.out_data); end
        end
        drive(1, 3, 0, 1, 0, 0);
        checks += 2;
        if (bus.out_data !== 8'd211) begin errors++; $display("FAIL bp_release: got %0d want 211", bus.out_data); end
        if (bus.sample_cnt !== 8'd0) begin errors++; $display("FAIL bp_cnt: got %0d want 0", bus.sample_cnt); end
        drive(1, 9, 0, 1, 0, 0);
        checks++;
        if (bus.out_data !== 8'd9) begin errors++; $display("FAIL bp_next_abs: got %0d want 9", bus.out_data); end
        drive(0, 0, 0, 1, 0, 0);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_sync_idle();
        drive(0, 0, 1, 1, 0, 0);
        drive(1, 8'h80, 0, 1, 0, 0);
        checks += 2;
        if (bus.out_data !== 8'd128) begin errors++; $display("FAIL sync_abs: got %0d want 128", bus.out_data); end
        if (bus.sample_cnt !== 8'd1) begin errors++; $display("FAIL sync_cnt: got %0d want 1", bus.sample_cnt); end
        drive(1, 2, 0, 1, 0, 0);
        checks++;
        if (bus.out_data !== 8'd130) begin errors++; $display("FAIL sync_delta: got %0d want 130", bus.out_data); end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 1, 0, 0);
        drive(1, 50, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        checks += 2;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL mid_held: got %0b want 1", bus.out_valid); end
        if (bus.out_data !== 8'd180) begin errors++; $display("FAIL mid_data: got %0d want 180", bus.out_data); end
        drive(0, 0, 0, 0, 0, 1);
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %0b want 0", bus.out_valid); end
        if (bus.out_data !== 8'd0) begin errors++; $display("FAIL mid_rst_data: got %0d want 0", bus.out_data); end
        if (bus.sample_cnt !== 8'd0) begin errors++; $display("FAIL mid_rst_cnt: got %0d want 0", bus.sample_cnt); end
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 8'h90, 0, 1, 0, 0);
        checks++;
        if (bus.out_data !== 8'd144) begin errors++; $display("FAIL mid_first_abs: got %0d want 144", bus.out_data); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                  $urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 99) == 0);
            checks += 5;
            if (bus.out_valid !== m_ov) begin errors++; $display("FAIL rand_valid[%0d]: got %0b want %0b", i, bus.out_valid, m_ov); end
            if (bus.out_data !== 8'(m_out)) begin errors++; $display("FAIL rand_data[%0d]: got %0d want %0d", i, bus.out_data, m_out); end
            if (bus.sat_err !== m_sat) begin errors++; $display("FAIL rand_sat[%0d]: got %0b want %0b", i, bus.sat_err, m_sat); end
            if (bus.sample_cnt !== 8'(m_pos)) begin errors++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, bus.sample_cnt, m_pos); end
            if (bus.in_ready !== (!m_ov || bus.out_ready)) begin errors++; $display("FAIL rand_in_ready[%0d]: got %0b want %0b", i, bus.in_ready, (!m_ov || bus.out_ready)); end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.sync = 1'b0;
        bus.out_ready = 1'b1; bus.sat_clr = 1'b0;
        m_ov = 0; m_out = 0; m_sat = 0; m_pos = 0; m_pend = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_saturation();
        test_resync();
        test_backpressure();
        test_sync_idle();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
